// File: rtl/speed_pulse_gen.sv
// rtl/speed_pulse_gen.sv - spreads Sa pulses evenly across each MP-cycle window
// Phase accumulator adds Sa every window cycle; each wrap past MP issues one pe a cycle later.
module speed_pulse_gen #(
  parameter int unsigned MP = 4250000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] Sd,
  input  logic       ld,
  input  logic       en,
  output logic       pe,
  output logic       win,
  output logic [7:0] Sa,
  output logic       pend,
  output logic [7:0] PC
);

  localparam logic [22:0] MP_C = 23'(MP);

  logic [22:0] cnt_q, cnt_d;
  logic [22:0] acc_q, acc_d;
  logic        carry_q, carry_d;
  logic        pe_q, pe_d;
  logic        win_q, win_d;
  logic [7:0]  sa_q, sa_d;
  logic        pend_q, pend_d;
  logic [7:0]  pval_q, pval_d;
  logic [7:0]  pc_q, pc_d;

  logic        boundary;
  logic [7:0]  sa_eff;
  logic [22:0] base;
  logic [23:0] sum;
  logic [22:0] wrapped;
  logic        carry;

  always_comb begin
    // cnt_q holds the last processed window cycle; 0 means the next enabled cycle restarts
    boundary = (cnt_q == 23'd0) || (cnt_q == MP_C);

    sa_eff = sa_q;
    if (boundary) begin
      if (ld) begin
        sa_eff = Sd;
      end else if (pend_q) begin
        sa_eff = pval_q;
      end
    end

    base    = boundary ? 23'd0 : acc_q;
    sum     = {1'b0, base} + {16'd0, sa_eff};
    carry   = (sum >= {1'b0, MP_C});
    wrapped = sum[22:0] - MP_C;

    cnt_d   = cnt_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    pe_d    = pe_q;
    win_d   = win_q;
    sa_d    = sa_q;
    pend_d  = pend_q;
    pval_d  = pval_q;
    pc_d    = pc_q;

    if (en && boundary) begin
      pend_d = 1'b0;
    end else if (ld) begin
      pval_d = Sd;
      pend_d = 1'b1;
    end

    if (en) begin
      cnt_d   = boundary ? 23'd1 : cnt_q + 23'd1;
      acc_d   = carry ? wrapped : sum[22:0];
      carry_d = carry;
      pe_d    = carry_q;
      win_d   = boundary;
      if (boundary) begin
        sa_d = sa_eff;
        pc_d = {7'd0, pe_d};
      end else if (pe_d && (pc_q != 8'hFF)) begin
        pc_d = pc_q + 8'd1;
      end
    end else begin
      // disabling drops the window and any carry not yet emitted
      cnt_d   = 23'd0;
      acc_d   = 23'd0;
      carry_d = 1'b0;
      pe_d    = 1'b0;
      win_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= 23'd0;
      acc_q   <= 23'd0;
      carry_q <= 1'b0;
      pe_q    <= 1'b0;
      win_q   <= 1'b0;
      sa_q    <= 8'd0;
      pend_q  <= 1'b0;
      pval_q  <= 8'd0;
      pc_q    <= 8'd0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      pe_q    <= pe_d;
      win_q   <= win_d;
      sa_q    <= sa_d;
      pend_q  <= pend_d;
      pval_q  <= pval_d;
      pc_q    <= pc_d;
    end
  end

  assign pe   = pe_q;
  assign win  = win_q;
  assign Sa   = sa_q;
  assign pend = pend_q;
  assign PC   = pc_q;

endmodule

// File: tb/tb_speed_pulse_gen.sv
// tb/tb_speed_pulse_gen.sv - scoreboard bench for speed_pulse_gen with MP=1000
module tb_speed_pulse_gen;

  localparam int MP = 1000;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] Sd;
  logic       ld;
  logic       en;
  logic       pe;
  logic       win;
  logic [7:0] Sa;
  logic       pend;
  logic [7:0] PC;

  speed_pulse_gen #(.MP(MP)) dut (
    .clk(clk), .reset(reset), .Sd(Sd), .ld(ld), .en(en),
    .pe(pe), .win(win), .Sa(Sa), .pend(pend), .PC(PC)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sa;
    int np;
    int pc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic push(input int sa, input int np, input int pc);
    exp_t e;
    e.sa = sa;
    e.np = np;
    e.pc = pc;
    q.push_back(e);
  endtask

  task automatic ld_val(input int v);
    @(posedge clk);
    #1 Sd = 8'(v);
    ld = 1'b1;
    @(posedge clk);
    #1 ld = 1'b0;
  endtask

  task automatic wait_drain();
    int budget;
    budget = (q.size() + 1) * MP + 200;
    while (q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("drain_pending_windows", q.size(), 0);
    q.delete();
  endtask

  task automatic wait_win();
    int b;
    b = MP + 50;
    do begin
      @(negedge clk);
      b--;
    end while (!win && b > 0);
    chk("win_seen", int'(win), 1);
  endtask

  // Monitor: closes a window record at each win that follows a full, uninterrupted window
  int  since = 0;
  int  np = 0;
  int  sa_rec = 0;
  int  pc_last = 0;
  bit  have_prev = 1'b0;
  bit  pe_last = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    since++;
    if (pe) begin
      np++;
      chk("pe_width", int'(pe_last), 0);
    end
    if (win) begin
      chk("pc_at_win", int'(PC), pe ? 1 : 0);
      if (have_prev && since == MP) begin
        if (q.size() == 0) begin
          chk("unexpected_window", 1, 0);
        end else begin
          e = q.pop_front();
          chk("win_sa", sa_rec, e.sa);
          chk("win_pulses", np, e.np);
          chk("win_pc_end", pc_last, e.pc);
        end
      end
      have_prev = 1'b1;
      since = 0;
      np = 0;
      sa_rec = int'(Sa);
    end
    pc_last = int'(PC);
    pe_last = pe;
  end

  initial begin
    int k;
    reset = 1'b1;
    en = 1'b0;
    ld = 1'b1;
    Sd = 8'd77;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pe", int'(pe), 0);
    chk("rst_win", int'(win), 0);
    chk("rst_pend", int'(pend), 0);
    chk("rst_pc", int'(PC), 0);
    chk("rst_sa", int'(Sa), 0);
    reset = 1'b0;
    ld = 1'b0;

    // V1: Sd=255 loaded while idle, then enable
    ld_val(255);
    chk("v1_pend", int'(pend), 1);
    push(255, 255, 254);
    push(255, 255, 255);
    en = 1'b1;
    wait_win();
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!pe && k < 20);
    chk("v1_first_pe_offset", k, 4);
    wait_drain();

    // V2: Sd=1
    push(255, 255, 255);
    ld_val(1);
    chk("v2_pend", int'(pend), 1);
    push(1, 1, 1);
    push(1, 1, 1);
    wait_drain();

    // V3: Sd=0
    push(1, 1, 1);
    ld_val(0);
    push(0, 0, 1);
    push(0, 0, 0);
    wait_drain();

    // V4: Sd=100 running, then mid-window load of 50
    push(0, 0, 0);
    ld_val(100);
    push(100, 100, 99);
    push(100, 100, 100);
    wait_drain();
    push(100, 100, 100);
    push(50, 50, 50);
    repeat (500) @(posedge clk);
    ld_val(50);
    chk("v4_pend_set", int'(pend), 1);
    chk("v4_sa_kept", int'(Sa), 100);
    wait_drain();
    chk("v4_pend_clear", int'(pend), 0);
    chk("v4_sa_new", int'(Sa), 50);

    // V5: load exactly in the boundary cycle
    push(50, 50, 50);
    push(50, 50, 50);
    push(20, 20, 20);
    wait_win();
    repeat (MP - 1) @(posedge clk);
    #1 Sd = 8'd20;
    ld = 1'b1;
    @(posedge clk);
    #1 ld = 1'b0;
    chk("v5_win", int'(win), 1);
    chk("v5_sa", int'(Sa), 20);
    chk("v5_pend", int'(pend), 0);
    wait_drain();

    // V6: reset at window cycle 500 with Sa=200
    push(20, 20, 20);
    ld_val(200);
    wait_win();
    chk("v6_sa_before", int'(Sa), 200);
    repeat (498) @(posedge clk);
    #1 reset = 1'b1;
    en = 1'b0;
    @(posedge clk);
    #1;
    chk("v6_pe", int'(pe), 0);
    chk("v6_win", int'(win), 0);
    chk("v6_pend", int'(pend), 0);
    chk("v6_pc", int'(PC), 0);
    chk("v6_sa", int'(Sa), 0);
    reset = 1'b0;
    ld_val(10);
    push(10, 10, 9);
    push(10, 10, 10);
    en = 1'b1;
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/speed_pulse_gen.md
SPEED_PULSE_GEN -- requirements
Module: speed_pulse_gen

Interface
REQ-001 The block SHALL take parameter MP, default 4250000, as the window length in clk cycles; legal range 256..8388607.
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 Sd  input  8  speed demand, pulses per window.
REQ-005 ld  input  1  one-cycle strobe; Sd is captured on the cycle ld is high.
REQ-006 en  input  1  generator enable.
REQ-007 pe  output  1  registered pulse output, one cycle wide.
REQ-008 win  output  1  registered one-cycle strobe marking window cycle 1.
REQ-009 Sa  output  8  speed value active in the current window.
REQ-010 pend  output  1  high while a captured Sd awaits the next window boundary.
REQ-011 PC  output  8  count of pe pulses issued in the current window.

Function
REQ-012 Window definition: cycles 1..MP counted from each win; a 23-bit window counter SHALL sequence them without gaps between consecutive windows.
REQ-013 Boundary, window cycle 1:
- Sa SHALL load the pending value if pend=1, otherwise keep its value.
- pend SHALL clear, and PC SHALL clear to 0 unless pe is high that cycle, in which case PC=1.
- The 23-bit phase accumulator SHALL restart from base 0 before the add of cycle 1.
REQ-014 Add rule, every window cycle n: sum = acc + Sa.
- If sum >= MP, acc SHALL load sum - MP and pe SHALL be high in cycle n+1.
- Otherwise acc SHALL load sum.
- Cycle n+1 for n=MP is cycle 1 of the next window.
REQ-015 Arithmetic SHALL be unsigned, with acc + Sa computed at 24 bits; Sa < MP guarantees at most one pulse per add.
REQ-016 Exactly Sa pulses SHALL result from the adds of each window, so a downstream pulse counter using the same MP reads back Sa.
REQ-017 PC SHALL increment on each pe and saturate at 255.
REQ-018 ld outside the boundary cycle: Sd SHALL be held in a pending register and pend SHALL set; a later ld before the boundary SHALL overwrite it.
REQ-019 ld in the boundary cycle: Sd SHALL apply directly to Sa in that same window, and pend SHALL stay 0.
REQ-020 Sa=0 SHALL produce no pulses while windows still run and win still strobes.
REQ-021 en=0:
- pe=0, win=0, acc=0, and the window counter held so the next enabled cycle is window cycle 1.
- Sa, PC and the pending register hold; ld capture still operates.
- The first cycle with en=1 SHALL be a boundary cycle, with win high.
REQ-022 en falling mid-window SHALL abandon the window; a pe pending from the last enabled add SHALL NOT be emitted.

Reset
REQ-023 When reset=1, at the next clk edge the block SHALL clear pe, win, pend, PC, Sa, acc, the pending register and the window counter to 0.
REQ-024 reset SHALL take priority over en and ld; a simultaneous ld SHALL be discarded.
REQ-025 The first enabled cycle after reset is deasserted SHALL be window cycle 1.
REQ-026 reset mid-window SHALL suppress any pulse due in the following cycle.

Verification
REQ-027 The bench SHALL cover these directed scenarios with MP=1000:
- V1: reset, ld Sd=255, en=1 -> pe first high 4 cycles after win (window cycle 5); exactly 255 pe per window; PC=255 at window end; no pe wider than 1 cycle.
- V2: Sd=1 -> single pe per window, coincident with the next win; PC reads 1 in that cycle.
- V3: Sd=0 -> win every 1000 cycles, pe never high, PC=0.
- V4: Sd=100 running; ld Sd=50 mid-window -> pend=1; remainder of window keeps Sa=100, 100 pulses; next window Sa=50, 50 pulses, pend=0.
- V5: ld in the boundary cycle with Sd=20 -> Sa=20 within that window, 20 pulses, pend never set.
- V6: reset asserted at window cycle 500 with Sa=200 -> all outputs 0 next cycle; after release and ld Sd=10, en=1 -> 10 pulses in the first full window.
